i2s_tx_serializer: RTL and testbench
====================================

Name: i2s_tx_serializer

Overview:
- Output stage directly downstream of the equalizer mixer.
- Accepts 16-bit mixed samples (the registered `dout` word) through a valid/ready handshake into a one-entry holding buffer.
- Serializes each sample in standard Philips I2S format to an external audio DAC, sending the same (mono) sample on both the left and right slots.
- Generates BCLK and LRCLK from the system clock, and counts underruns.

Parameters:
- DATA_W, 16: sample width; also the slot width in BCLK periods.
- BCLK_DIV, 4: clk cycles per BCLK half-period, ≥1. Frame length is 2*BCLK_DIV*2*DATA_W clk cycles (256 at defaults).
- UCNT_W, 8: width of the saturating underrun counter.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- sample_in  in  DATA_W  signed two's-complement sample.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  holding buffer empty; a sample is accepted when valid&&ready.
- bclk  out  1  I2S bit clock (registered).
- lrclk  out  1  I2S word select: 0 = left, 1 = right (registered).
- sdata  out  1  I2S serial data, MSB first (registered).
- frame_start  out  1  one-clk pulse on each frame load.
- underrun  out  1  one-clk pulse when a frame loads with the buffer empty.
- underrun_cnt  out  UCNT_W  saturating count of underruns.

Behaviour:
- Reset values (asynchronous, active-high): bclk=0, lrclk=1, sdata=0, frame_start=0, underrun=0, underrun_cnt=0, sample_ready=1.
  - Internal reset values: div_cnt=0, bit_cnt=2*DATA_W-1, buffer empty, last sample=0, shift register=0.
  - Reset mid-frame aborts the frame immediately and discards any buffered sample.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - At div_cnt==BCLK_DIV-1, bclk toggles.
  - The toggle 1→0 is the "fall tick"; all serial state changes only on fall ticks.
- On each fall tick:
  - bit_cnt <= (bit_cnt+1) mod 2*DATA_W.
  - lrclk <= (new bit_cnt ≥ DATA_W).
- I2S one-bit delay: sdata carries bit (new bit_cnt − 1) of the frame word.
  - Frame word is {S,S}, MSB first, where S is the sample loaded for this frame.
  - The right-slot LSB is driven on the fall tick where bit_cnt wraps to 0 (the next frame's first tick).
- Frame load: on the fall tick where new bit_cnt==0:
  - Buffer full: S = buffer; buffer cleared; last sample <= S.
  - Buffer empty: S = last sample (see the optional feature); underrun pulses; underrun_cnt increments, saturating at all-ones.
  - frame_start pulses in the same cycle.
- First fall tick after reset is a frame load. With no sample supplied by then, it counts as an underrun.
- Handshake:
  - sample_ready = buffer empty (registered).
  - Accept when sample_valid && sample_ready; the buffer is full from the next cycle.
  - sample_valid while not ready is ignored; no overwrite or queueing.
- Simultaneous load and valid with the buffer empty: the load sees empty (underrun), and the sample is captured in the buffer for the next frame.
- Latency: a sample accepted before a load tick has its MSB on sdata from the load tick+1 fall tick, i.e. 2*BCLK_DIV clk cycles after that load.
- sdata and lrclk change only on bclk falling edges, so the DAC samples them on rising edges.

Optional Feature:
- Macro: I2S_UNDERRUN_MUTE_EN.
- Defined: an underrun frame transmits S=0 (mute), and last sample is set to 0.
- Undefined: an underrun frame repeats the last transmitted sample (0 after reset).
- underrun and underrun_cnt behave identically in both builds.

Decomposition:
- Shared package `audio_pkg`: DATA_W default, the sample typedef (signed [15:0]), and the I2S frame-length constant.
- Natural sub-module: `bclk_gen` (divider, bclk register, fall-tick strobe).
- The shift register, bit counter, handshake buffer and underrun logic stay in the top module.

Test Plan:
- Reset release, no input, BCLK_DIV=2:
  - First fall tick after 4 clk cycles gives frame_start=1, underrun=1, underrun_cnt=1.
  - sdata stays 0 for the whole frame, and lrclk=0 for 16 BCLKs then 1 for 16.
- Present 16'hA5C3 with valid held: ready drops the next cycle.
  - Next frame sends left bits A5C3 MSB-first, starting one BCLK after lrclk falls, then right A5C3.
  - R LSB=1 appears on the following frame's first tick; ready=1 again after the load.
- Stream 16'h8001, 16'h7FFE, one per frame with valid asserted only while ready:
  - Exact bit sequences match, with no underrun pulses over 4 frames.
- Stop input after 16'h1234:
  - Undefined-macro build repeats 1234.
  - I2S_UNDERRUN_MUTE_EN build sends 0000.
  - Both builds increment underrun_cnt once per empty frame; force 300 underruns and check the count saturates at 255.
- Assert valid exactly on the load cycle with the buffer empty:
  - That frame underruns, and the sample is transmitted in the next frame.
- Assert reset mid-right-slot with the buffer full:
  - All outputs return to reset values immediately, and the buffered sample is never transmitted.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: constants and types shared by the audio output path.
// Sample width default, the signed sample type, and I2S frame-length helpers.
package audio_pkg;

  localparam int AUDIO_DATA_W = 16;
  localparam int I2S_SLOTS    = 2;
  // Frame length in BCLK periods: one left slot plus one right slot.
  localparam int I2S_FRAME_BCLKS = I2S_SLOTS * AUDIO_DATA_W;

  typedef logic signed [AUDIO_DATA_W-1:0] sample_t;

  // Frame length in system clocks for a given BCLK half-period divider.
  function automatic int i2s_frame_clks(input int bclk_div);
    return 2 * bclk_div * I2S_FRAME_BCLKS;
  endfunction

endpackage

// File: rtl/bclk_gen.sv
// bclk_gen: divides the system clock down to the I2S bit clock.
// The bit clock toggles every BCLK_DIV system clocks. o_fall_tick is high in
// the cycle whose rising clk edge takes bclk from 1 to 0. All serial state
// downstream advances on that edge.
module bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_bclk,
  output logic o_fall_tick
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_bclk;
  logic             w_wrap;

  assign w_wrap      = (r_div_cnt == DIV_LAST);
  assign o_fall_tick = w_wrap && r_bclk;
  assign o_bclk      = r_bclk;

  // Half-period divider; bclk toggles when the divider wraps.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: mono sample to Philips I2S transmitter.
// A one-entry buffer takes samples through a valid/ready handshake. Each frame
// sends the same sample in the left and right slots, MSB first, with the I2S
// one-bit delay. Underruns are counted in a saturating counter.
// Build option I2S_UNDERRUN_MUTE_EN: when defined, an underrun frame sends
// silence. When undefined, an underrun frame repeats the last sample sent.
module i2s_tx_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W   = AUDIO_DATA_W,
  parameter int BCLK_DIV = 4,
  parameter int UCNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  output logic                     bclk,
  output logic                     lrclk,
  output logic                     sdata,
  output logic                     frame_start,
  output logic                     underrun,
  output logic [UCNT_W-1:0]        underrun_cnt
);

  localparam int FRAME_W = 2 * DATA_W;
  localparam int BC_W    = $clog2(FRAME_W);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(FRAME_W - 1);
  localparam logic [BC_W-1:0] BC_RIGHT = BC_W'(DATA_W);

`ifdef I2S_UNDERRUN_MUTE_EN
  localparam bit MUTE_ON_UNDERRUN = 1'b1;
`else
  localparam bit MUTE_ON_UNDERRUN = 1'b0;
`endif

  logic               w_fall_tick;
  logic               w_load;
  logic               w_accept;
  logic [BC_W-1:0]    w_bit_next;
  logic [DATA_W-1:0]  w_load_sample;

  logic [BC_W-1:0]    r_bit_cnt;
  logic [FRAME_W-1:0] r_shift;
  logic               r_lrclk;
  logic               r_sdata;
  logic               r_buf_full;
  logic [DATA_W-1:0]  r_buf;
  logic [DATA_W-1:0]  r_last;
  logic               r_frame_start;
  logic               r_underrun;
  logic [UCNT_W-1:0]  r_ucnt;

  bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .i_clk       (clk),
    .i_reset     (reset),
    .o_bclk      (bclk),
    .o_fall_tick (w_fall_tick)
  );

  assign w_load   = w_fall_tick && (w_bit_next == '0);
  assign w_accept = sample_valid && !r_buf_full;

  // Next position in the frame, wrapping after the right-slot LSB.
  always_comb begin
    w_bit_next = r_bit_cnt + 1'b1;
    if (r_bit_cnt == BC_LAST) w_bit_next = '0;
  end

  // Select the word for a new frame: the buffered sample, or the underrun fill value.
  always_comb begin
    w_load_sample = r_last;
    if (r_buf_full)            w_load_sample = r_buf;
    else if (MUTE_ON_UNDERRUN) w_load_sample = '0;
  end

  // Serial path. sdata shifts out the MSB before the register reloads, which
  // gives the one-bit I2S delay and puts the previous right-slot LSB on the load tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= BC_LAST;
      r_lrclk   <= 1'b1;
      r_sdata   <= 1'b0;
      r_shift   <= '0;
    end else if (w_fall_tick) begin
      r_bit_cnt <= w_bit_next;
      r_lrclk   <= (w_bit_next >= BC_RIGHT);
      r_sdata   <= r_shift[FRAME_W-1];
      if (w_load) r_shift <= {w_load_sample, w_load_sample};
      else        r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
    end
  end

  // Holding buffer. A frame load empties it; a load that finds it empty
  // can still accept a sample in the same cycle, for the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf_full <= 1'b0;
      r_buf      <= '0;
      r_last     <= '0;
    end else begin
      if (w_load) r_last <= w_load_sample;
      if (w_load && r_buf_full) begin
        r_buf_full <= 1'b0;
      end else if (w_accept) begin
        r_buf_full <= 1'b1;
        r_buf      <= sample_in;
      end
    end
  end

  // Frame and underrun strobes, and the saturating underrun counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_ucnt        <= '0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load && !r_buf_full;
      if (w_load && !r_buf_full && (r_ucnt != '1)) r_ucnt <= r_ucnt + 1'b1;
    end
  end

  assign sample_ready = !r_buf_full;
  assign lrclk        = r_lrclk;
  assign sdata        = r_sdata;
  assign frame_start  = r_frame_start;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_ucnt;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: directed bench for the I2S transmitter (BCLK_DIV=2).
// A bclk-rising-edge monitor rebuilds the 32-bit frame words, as a DAC would.
// The stimulus list holds the expected words, worked out by hand.
module tb_i2s_tx_serializer;

  localparam int BCLK_DIV   = 2;
  localparam int FRAME_CLKS = 128;   // 2*BCLK_DIV*32

`ifdef I2S_UNDERRUN_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic               sample_ready;
  logic               bclk, lrclk, sdata, frame_start, underrun;
  logic [7:0]         underrun_cnt;

  i2s_tx_serializer #(.DATA_W(16), .BCLK_DIV(BCLK_DIV), .UCNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .frame_start  (frame_start),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_bclk"},  32'(bclk), 32'd0);
    check({pfx, "_lrclk"}, 32'(lrclk), 32'd1);
    check({pfx, "_sdata"}, 32'(sdata), 32'd0);
    check({pfx, "_fs"},    32'(frame_start), 32'd0);
    check({pfx, "_ur"},    32'(underrun), 32'd0);
    check({pfx, "_ucnt"},  32'(underrun_cnt), 32'd0);
    check({pfx, "_ready"}, 32'(sample_ready), 32'd1);
  endtask

  // Wait, with a bound, for the negedge just after a frame load; returns clocks waited.
  task automatic wait_fs(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (frame_start !== 1'b1 && cyc < 4 * FRAME_CLKS);
    if (frame_start !== 1'b1) check("fs_timeout", 32'd0, 32'd1);
  endtask

  // Frame capture on bclk rising edges. Rise 1 comes before the first load.
  // Rise 2 carries the pre-frame bit. Rises 3.. carry frame f, bit index i.
  int          rst_epoch = 0;
  int          mon_epoch = 0;
  int          rise_n = 0;
  logic [31:0] cur_word = '0;
  logic [31:0] cap_q[$];

  always @(posedge bclk) begin
    #1;
    if (mon_epoch != rst_epoch) begin
      mon_epoch = rst_epoch;
      rise_n    = 0;
    end
    rise_n++;
    if (rise_n == 1) begin
      check("lrclk_preframe", 32'(lrclk), 32'd1);
    end else begin
      check("lrclk", 32'(lrclk), 32'(((rise_n - 2) % 32) >= 16));
      if (rise_n >= 3) begin
        cur_word[31 - ((rise_n - 3) % 32)] = sdata;
        if (((rise_n - 3) % 32) == 31) cap_q.push_back(cur_word);
      end
    end
  end

  int ur_total = 0;
  always @(negedge clk) if (underrun === 1'b1) ur_total++;

  logic [31:0] exp_q[$];
  logic [15:0] stream[5] = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE, 16'h1234};

  initial begin
    int          cyc;
    int          ur0;
    int          e_cnt;
    logic [31:0] rep;
    logic [31:0] exp_w;

    rep = MUTE ? 32'h0 : 32'h1234_1234;

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;

    // First load, with nothing supplied: an underrun frame of zeros.
    wait_fs(cyc);
    check("first_fs_cycles", 32'(cyc), 32'd4);
    check("f0_underrun", 32'(underrun), 32'd1);
    check("f0_ucnt", 32'(underrun_cnt), 32'd1);
    exp_q.push_back(32'h0);

    // A5C3 handshake: ready drops one cycle after acceptance.
    check("a5_ready_before", 32'(sample_ready), 32'd1);
    sample_in = 16'hA5C3; sample_valid = 1'b1;
    @(negedge clk);
    check("a5_ready_after", 32'(sample_ready), 32'd0);
    sample_valid = 1'b0;
    wait_fs(cyc);
    check("f1_underrun", 32'(underrun), 32'd0);
    check("f1_ready", 32'(sample_ready), 32'd1);
    check("f1_ucnt", 32'(underrun_cnt), 32'd1);
    exp_q.push_back(32'hA5C3_A5C3);

    // Stream one sample per frame, valid only while ready.
    ur0 = ur_total;
    foreach (stream[k]) begin
      sample_in = stream[k]; sample_valid = 1'b1;
      @(negedge clk);
      check("stream_accept", 32'(sample_ready), 32'd0);
      sample_valid = 1'b0;
      wait_fs(cyc);
      check("stream_underrun", 32'(underrun), 32'd0);
      exp_q.push_back({stream[k], stream[k]});
    end
    check("stream_no_ur", 32'(ur_total - ur0), 32'd0);

    // Input stops: two underrun frames.
    for (int k = 0; k < 2; k++) begin
      wait_fs(cyc);
      check("stop_underrun", 32'(underrun), 32'd1);
      check("stop_ucnt", 32'(underrun_cnt), 32'(2 + k));
      exp_q.push_back(rep);
    end

    // Valid arrives on the load edge itself, with the buffer empty.
    repeat (FRAME_CLKS - 1) @(negedge clk);
    sample_in = 16'h5A3C; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("race_fs", 32'(frame_start), 32'd1);
    check("race_underrun", 32'(underrun), 32'd1);
    check("race_captured", 32'(sample_ready), 32'd0);
    check("race_ucnt", 32'(underrun_cnt), 32'd4);
    exp_q.push_back(rep);
    wait_fs(cyc);
    check("race_next_ur", 32'(underrun), 32'd0);
    check("race_next_ucnt", 32'(underrun_cnt), 32'd4);
    exp_q.push_back(32'h5A3C_5A3C);
    wait_fs(cyc);
    check("pre_rst_ucnt", 32'(underrun_cnt), 32'd5);

    // Fill the buffer, then reset in the middle of the right slot.
    sample_in = 16'h0F0F; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("rst_buf_full", 32'(sample_ready), 32'd0);
    repeat (94) @(negedge clk);
    reset = 1'b1;
    rst_epoch++;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;

    // From here on, every frame underruns. The counter saturates at 255.
    e_cnt = 0;
    for (int k = 1; k <= 300; k++) begin
      wait_fs(cyc);
      if (k == 1) check("rst_first_fs_cycles", 32'(cyc), 32'd4);
      e_cnt++;
      check("sat_underrun", 32'(underrun), 32'd1);
      check("sat_ucnt", 32'(underrun_cnt), 32'((e_cnt > 255) ? 255 : e_cnt));
    end

    // Captured frames: the expected list, then only zero frames after the reset.
    check("frames_captured", 32'(cap_q.size() >= exp_q.size() + 2), 32'd1);
    for (int i = 0; i < cap_q.size(); i++) begin
      exp_w = (i < exp_q.size()) ? exp_q[i] : 32'h0;
      check($sformatf("frame%0d", i), cap_q[i], exp_w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
